// File: rtl/spsr_burst_pkg.sv
// Shared definitions for the burst SRAM: FSM encoding, legal read latencies
// and the byte-lane count derived from the data width.
package spsr_burst_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } state_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   function automatic int be_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/spsr_bram_be.sv
// Single-port storage array: byte-enabled synchronous write, registered read.
// Contents are never reset.
module spsr_bram_be
   import spsr_burst_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                            clk,
   input  logic                            we,
   input  logic                            re,
   input  logic [ADDR_WIDTH-1:0]           addr,
   input  logic [be_width(DATA_WIDTH)-1:0] be,
   input  logic [DATA_WIDTH-1:0]           wdata,
   output logic [DATA_WIDTH-1:0]           rdata
);

   localparam int BE_WIDTH  = be_width(DATA_WIDTH);
   localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/spsr_burst.sv
// Burst-capable single-port SRAM front end: request handshake, incrementing
// write/read bursts with byte enables, and a 1- or 2-cycle read pipeline.
module spsr_burst
   import spsr_burst_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int LEN_WIDTH  = 4,
   parameter int RD_LAT     = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cs,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic                            req_we,
   input  logic [ADDR_WIDTH-1:0]           req_addr,
   input  logic [LEN_WIDTH-1:0]            req_len,
   input  logic                            wr_valid,
   output logic                            wr_ready,
   input  logic [DATA_WIDTH-1:0]           wr_data,
   input  logic [be_width(DATA_WIDTH)-1:0] wr_be,
   output logic                            rd_valid,
   output logic [DATA_WIDTH-1:0]           rd_data,
   output logic                            rd_last,
   output logic                            busy
);

   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $fatal(1, "spsr_burst: RD_LAT must be 1 or 2");
   end
   if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
      $fatal(1, "spsr_burst: DATA_WIDTH must be a multiple of 8");
   end

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_nxt;
   logic                  accept, wr_fire, rd_issue, last_beat;
   logic                  vld_p0, last_p0;
   logic [DATA_WIDTH-1:0] data_p0;
   logic                  vld_out, last_out, pipe_busy;
   logic [DATA_WIDTH-1:0] data_out;

   // A read burst can hand over to the next request on its final issue
   // cycle, so back-to-back reads stream without a bubble.
   always_comb begin
      last_beat = (cnt_q == '0);
      req_ready = !rst && ((state == ST_IDLE) || (state == ST_READ && last_beat));
      accept    = req_valid && req_ready && cs;
      wr_ready  = (state == ST_WRITE);
      wr_fire   = wr_valid && wr_ready;
      rd_issue  = (state == ST_READ);
      state_nxt = state;
      addr_nxt  = addr_q;
      cnt_nxt   = cnt_q;
      case (state)
         ST_WRITE: begin
            if (wr_fire) begin
               addr_nxt = addr_q + 1'b1;
               cnt_nxt  = cnt_q - 1'b1;
               if (last_beat) state_nxt = ST_IDLE;
            end
         end
         ST_READ: begin
            addr_nxt = addr_q + 1'b1;
            cnt_nxt  = cnt_q - 1'b1;
            if (last_beat) state_nxt = ST_IDLE;
         end
         default: ;
      endcase
      if (accept) begin
         addr_nxt  = req_addr;
         cnt_nxt   = req_len;
         state_nxt = req_we ? ST_WRITE : ST_READ;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt_q <= '0;
      end else begin
         state <= state_nxt;
         cnt_q <= cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      addr_q <= addr_nxt;
   end

   spsr_bram_be #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_bram (
      .clk  (clk),
      .we   (wr_fire),
      .re   (rd_issue),
      .addr (addr_q),
      .be   (wr_be),
      .wdata(wr_data),
      .rdata(data_p0)
   );

   // Stage p0: array read register, valid/last tracked alongside
   always_ff @(posedge clk) begin
      if (rst) vld_p0 <= 1'b0;
      else     vld_p0 <= rd_issue;
   end

   always_ff @(posedge clk) begin
      last_p0 <= rd_issue && last_beat;
   end

   if (RD_LAT == 2) begin : g_lat2
      logic                  vld_p1, last_p1;
      logic [DATA_WIDTH-1:0] data_p1;

      // Stage p1: optional output register
      always_ff @(posedge clk) begin
         if (rst) vld_p1 <= 1'b0;
         else     vld_p1 <= vld_p0;
      end

      always_ff @(posedge clk) begin
         last_p1 <= last_p0;
         data_p1 <= data_p0;
      end

      assign vld_out   = vld_p1;
      assign last_out  = last_p1;
      assign data_out  = data_p1;
      assign pipe_busy = vld_p0 || vld_p1;
   end else begin : g_lat1
      assign vld_out   = vld_p0;
      assign last_out  = last_p0;
      assign data_out  = data_p0;
      assign pipe_busy = vld_p0;
   end

   assign rd_valid = vld_out;
   assign rd_last  = vld_out && last_out;
   assign rd_data  = vld_out ? data_out : '0;
   assign busy     = (state != ST_IDLE) || pipe_busy;

endmodule

// File: tb/tb_spsr_burst.sv
// Directed bench for spsr_burst (RD_LAT=2): vector table for single-beat
// traffic plus hand-written wrap, stall, back-to-back and reset sequences.
module tb_spsr_burst;

   localparam int DW = 16;
   localparam int AW = 16;
   localparam int LW = 4;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cs = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [LW-1:0] req_len = '0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [DW-1:0] wr_data = '0;
   logic [1:0]    wr_be = '0;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          rd_last;
   logic          busy;

   spsr_burst #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .LEN_WIDTH (LW),
      .RD_LAT    (LAT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cs       (cs),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we   (req_we),
      .req_addr (req_addr),
      .req_len  (req_len),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_data  (wr_data),
      .wr_be    (wr_be),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .rd_last  (rd_last),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
      int            c;
   } beat_t;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [1:0]    be;
      logic [DW-1:0] exp;
   } vec_t;

   int    cyc = 0;
   int    busy_cyc = -1;
   int    checks = 0;
   int    errors = 0;
   beat_t rdq[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rd_valid) rdq.push_back('{rd_data, rd_last, cyc});
      if (busy) busy_cyc = cyc;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a request until accepted; returns in the first cycle of the burst.
   task automatic req(input logic we, input logic [AW-1:0] a, input int len);
      int n = 0;
      cs = 1'b1; req_valid = 1'b1; req_we = we; req_addr = a; req_len = LW'(len);
      #1;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      chk("req_accept_timeout", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wr_burst(input logic [AW-1:0] a, input int len, input logic [DW-1:0] d0,
                           input logic [1:0] be);
      req(1'b1, a, len);
      for (int i = 0; i <= len; i++) begin
         wr_valid = 1'b1; wr_data = d0 + DW'(i); wr_be = be;
         tick();
      end
      wr_valid = 1'b0;
   endtask

   task automatic rd_burst(input logic [AW-1:0] a, input int len, output int issue);
      req(1'b0, a, len);
      issue = cyc;
   endtask

   task automatic wait_beats(input int n);
      int t = 0;
      while (rdq.size() < n && t < 100) begin
         tick();
         t++;
      end
      chk("beat_count", 32'(rdq.size()), 32'(n));
   endtask

   vec_t  vecs[8];
   beat_t b;
   int    iss, iss1;
   logic [1:0] stall_pat[7];
   int    wn;

   initial begin
      vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000};
      vecs[1] = '{1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF};
      vecs[2] = '{1'b1, 16'h0020, 16'hBEEF, 2'b11, 16'h0000};
      vecs[3] = '{1'b1, 16'h0020, 16'h1234, 2'b01, 16'h0000};
      vecs[4] = '{1'b0, 16'h0020, 16'h0000, 2'b00, 16'hBE34};
      vecs[5] = '{1'b1, 16'h0020, 16'hFFFF, 2'b00, 16'h0000};
      vecs[6] = '{1'b0, 16'h0020, 16'h0000, 2'b00, 16'hBE34};
      vecs[7] = '{1'b1, 16'h0030, 16'hA5C3, 2'b10, 16'h0000};

      // Reset state
      repeat (3) tick();
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_wr_ready", 32'(wr_ready), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_rd_last", 32'(rd_last), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      #1;
      chk("post_rst_req_ready", 32'(req_ready), 1);

      // cs low blocks acceptance but req_ready still reads 1
      cs = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; req_len = '0;
      tick();
      chk("cs_low_busy", 32'(busy), 0);
      chk("cs_low_req_ready", 32'(req_ready), 1);
      req_valid = 1'b0;
      tick();
      chk("cs_low_no_read", 32'(rdq.size()), 0);

      wr_burst(16'h0030, 0, 16'h0000, 2'b11);
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].we) begin
            wr_burst(vecs[i].addr, 0, vecs[i].data, vecs[i].be);
         end else begin
            rdq.delete();
            rd_burst(vecs[i].addr, 0, iss);
            wait_beats(1);
            if (rdq.size() > 0) begin
               b = rdq.pop_front();
               chk($sformatf("vec%0d_data", i), 32'(b.d), 32'(vecs[i].exp));
               chk($sformatf("vec%0d_last", i), 32'(b.l), 1);
               chk($sformatf("vec%0d_latency", i), 32'(b.c - iss), 32'(LAT));
            end
         end
      end
      rdq.delete();
      rd_burst(16'h0030, 0, iss);
      wait_beats(1);
      if (rdq.size() > 0) begin
         b = rdq.pop_front();
         chk("be_hi_only_data", 32'(b.d), 32'h0000A500);
      end

      // Wrap burst across the top of memory
      wr_burst(16'hFFFE, 3, 16'h0001, 2'b11);
      rdq.delete();
      rd_burst(16'hFFFE, 3, iss);
      wait_beats(4);
      for (int i = 0; i < 4 && i < rdq.size(); i++) begin
         chk($sformatf("wrap_data%0d", i), 32'(rdq[i].d), 32'(i + 1));
         chk($sformatf("wrap_last%0d", i), 32'(rdq[i].l), 32'(i == 3));
         chk($sformatf("wrap_cyc%0d", i), 32'(rdq[i].c), 32'(iss + LAT + i));
      end
      rdq.delete();
      rd_burst(16'h0000, 1, iss);
      wait_beats(2);
      if (rdq.size() == 2) begin
         chk("wrap_mem0", 32'(rdq[0].d), 3);
         chk("wrap_mem1", 32'(rdq[1].d), 4);
      end

      // Write stall: 4 beats spread over 7 cycles
      wr_burst(16'h0044, 0, 16'hDEAD, 2'b11);
      stall_pat = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1};
      req(1'b1, 16'h0040, 3);
      wn = 0;
      for (int i = 0; i < 7; i++) begin
         wr_valid = stall_pat[i][0];
         wr_data = 16'h1000 + DW'(wn);
         wr_be = 2'b11;
         req_valid = 1'b1; req_we = 1'b0;
         #1;
         chk($sformatf("stall_req_ready%0d", i), 32'(req_ready), 0);
         chk($sformatf("stall_wr_ready%0d", i), 32'(wr_ready), 1);
         if (stall_pat[i][0]) wn++;
         req_valid = 1'b0;
         tick();
      end
      wr_valid = 1'b1;
      #1;
      chk("stall_done_req_ready", 32'(req_ready), 1);
      chk("idle_wr_ready", 32'(wr_ready), 0);
      wr_valid = 1'b0;
      rdq.delete();
      rd_burst(16'h0040, 4, iss);
      wait_beats(5);
      for (int i = 0; i < 5 && i < rdq.size(); i++) begin
         chk($sformatf("stall_mem%0d", i), 32'(rdq[i].d), (i < 4) ? 32'(16'h1000 + i) : 32'hDEAD);
      end

      // Back-to-back reads stream without a gap
      wr_burst(16'h0100, 3, 16'h00A0, 2'b11);
      wr_burst(16'h0200, 1, 16'h00B0, 2'b11);
      repeat (2) tick();
      rdq.delete();
      rd_burst(16'h0100, 3, iss);
      rd_burst(16'h0200, 1, iss1);
      wait_beats(6);
      repeat (3) tick();
      chk("b2b_issue_gap", 32'(iss1 - iss), 4);
      for (int i = 0; i < 6 && i < rdq.size(); i++) begin
         chk($sformatf("b2b_data%0d", i), 32'(rdq[i].d), (i < 4) ? 32'(16'h00A0 + i) : 32'(16'h00B0 + i - 4));
         chk($sformatf("b2b_last%0d", i), 32'(rdq[i].l), 32'(i == 3 || i == 5));
         chk($sformatf("b2b_cyc%0d", i), 32'(rdq[i].c), 32'(iss + LAT + i));
      end
      chk("b2b_busy_last_cycle", 32'(busy_cyc), 32'(iss1 + 1 + LAT));
      chk("b2b_busy_idle", 32'(busy), 0);

      // Reset during beat 2 of an 8-beat read
      wr_burst(16'h0300, 7, 16'h0C00, 2'b11);
      rdq.delete();
      rd_burst(16'h0300, 7, iss);
      repeat (1 + LAT) tick();
      chk("mid_rst_beat2_valid", 32'(rd_valid), 1);
      rst = 1'b1;
      tick();
      chk("mid_rst_rd_valid", 32'(rd_valid), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      rst = 1'b0;
      #1;
      chk("mid_rst_req_ready", 32'(req_ready), 1);
      repeat (5) tick();
      chk("mid_rst_beats_seen", 32'(rdq.size()), 2);
      rdq.delete();
      rd_burst(16'h0010, 0, iss);
      wait_beats(1);
      if (rdq.size() > 0) chk("mid_rst_mem_kept", 32'(rdq[0].d), 32'hBEEF);
      rdq.delete();
      rd_burst(16'h0307, 0, iss);
      wait_beats(1);
      if (rdq.size() > 0) chk("mid_rst_burst_data", 32'(rdq[0].d), 32'h0C07);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
